// File: rtl/pwm_deadtime_pkg.sv
// Shared types for the dead-time generator: per-channel state enum and encodings.
package pwm_deadtime_pkg;

  localparam int unsigned CHNL_NUM_DEF = 4;
  localparam int unsigned DT_WIDTH_DEF = 8;
  localparam int unsigned ST_WIDTH     = 3;

  localparam logic [ST_WIDTH-1:0] ST_OFF_C     = 3'd0;
  localparam logic [ST_WIDTH-1:0] ST_LOW_ON_C  = 3'd1;
  localparam logic [ST_WIDTH-1:0] ST_DEAD_H_C  = 3'd2;
  localparam logic [ST_WIDTH-1:0] ST_HIGH_ON_C = 3'd3;
  localparam logic [ST_WIDTH-1:0] ST_DEAD_L_C  = 3'd4;

  typedef enum logic [ST_WIDTH-1:0] {
    ST_OFF     = ST_OFF_C,
    ST_LOW_ON  = ST_LOW_ON_C,
    ST_DEAD_H  = ST_DEAD_H_C,
    ST_HIGH_ON = ST_HIGH_ON_C,
    ST_DEAD_L  = ST_DEAD_L_C
  } chnl_state_e;

endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/gate-drive bundle between the PWM timer side and the dead-time block.
interface pwm_deadtime_if #(
  parameter int unsigned CHNL_NUM = 4,
  parameter int unsigned DT_WIDTH = 8
);
  logic                en_i;
  logic                brk_i;
  logic [DT_WIDTH-1:0] dt_i;
  logic [CHNL_NUM-1:0] pwm_i;
  logic [CHNL_NUM-1:0] pwm_h_o;
  logic [CHNL_NUM-1:0] pwm_l_o;
  logic                brk_o;

  modport master (output en_i, brk_i, dt_i, pwm_i, input pwm_h_o, pwm_l_o, brk_o);
  modport slave  (input en_i, brk_i, dt_i, pwm_i, output pwm_h_o, pwm_l_o, brk_o);
endinterface

// File: rtl/pwm_deadtime_chnl.sv
// One half-bridge channel: Moore FSM inserting dt_i dead cycles between high- and low-side drive.
module pwm_deadtime_chnl
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                brk_i,
  input  logic                hold_i,
  input  logic [DT_WIDTH-1:0] dt_i,
  input  logic                pwm_i,
  output logic                pwm_h_o,
  output logic                pwm_l_o
);

  chnl_state_e         state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                h_q, l_q;
  logic                dt_zero;
  logic [DT_WIDTH-1:0] cnt_load;

  assign dt_zero  = (dt_i == '0);
  assign cnt_load = dt_zero ? '0 : dt_i - DT_WIDTH'(1);

  // Next state; dt_i is only consumed on entry to a dead state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (brk_i || !en_i || hold_i) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          cnt_d = cnt_load;
          if (pwm_i) state_d = dt_zero ? ST_HIGH_ON : ST_DEAD_H;
          else       state_d = dt_zero ? ST_LOW_ON  : ST_DEAD_L;
        end
        ST_LOW_ON: if (pwm_i) begin
          cnt_d   = cnt_load;
          state_d = dt_zero ? ST_HIGH_ON : ST_DEAD_H;
        end
        ST_HIGH_ON: if (!pwm_i) begin
          cnt_d   = cnt_load;
          state_d = dt_zero ? ST_LOW_ON : ST_DEAD_L;
        end
        ST_DEAD_H: begin
          if (!pwm_i)            state_d = ST_LOW_ON;
          else if (cnt_q == '0)  state_d = ST_HIGH_ON;
          else                   cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        ST_DEAD_L: begin
          if (pwm_i)             state_d = ST_HIGH_ON;
          else if (cnt_q == '0)  state_d = ST_LOW_ON;
          else                   cnt_d   = cnt_q - DT_WIDTH'(1);
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Gate flops mirror the state register, so h and l can never coincide
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      h_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= (state_d == ST_HIGH_ON);
      l_q     <= (state_d == ST_LOW_ON);
    end
  end

  assign pwm_h_o = h_q;
  assign pwm_l_o = l_q;

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-channel dead-time inserter with a shared sticky break flag.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned CHNL_NUM = CHNL_NUM_DEF,
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pwm_deadtime_if.slave  bus
);

  logic                brk_q, brk_d;
  logic [CHNL_NUM-1:0] pwm_h, pwm_l;

  // Break stays latched until an edge sees both en_i and brk_i low
  always_comb brk_d = bus.brk_i | (brk_q & bus.en_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) brk_q <= 1'b0;
    else       brk_q <= brk_d;
  end

  for (genvar i = 0; i < CHNL_NUM; i++) begin : g_chnl
    pwm_deadtime_chnl #(.DT_WIDTH(DT_WIDTH)) u_chnl (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (bus.en_i),
      .brk_i   (bus.brk_i),
      .hold_i  (brk_q),
      .dt_i    (bus.dt_i),
      .pwm_i   (bus.pwm_i[i]),
      .pwm_h_o (pwm_h[i]),
      .pwm_l_o (pwm_l[i])
    );
  end

  assign bus.pwm_h_o = pwm_h;
  assign bus.pwm_l_o = pwm_l;
  assign bus.brk_o   = brk_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: behavioural channel model plus directed scenarios.
module tb_pwm_deadtime;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 8;
  localparam int M_OFF = 0, M_LOW = 1, M_DH = 2, M_HIGH = 3, M_DL = 4;

  typedef logic [2*CH:0] obs_t;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  pwm_deadtime_if #(.CHNL_NUM(CH), .DT_WIDTH(DW)) bus ();

  pwm_deadtime #(.CHNL_NUM(CH), .DT_WIDTH(DW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t exp_q [$];

  int   m_st   [CH];
  int   m_left [CH];
  logic m_brk;

  int   run       [CH];
  int   mindt     [CH];
  int   last_side [CH];
  bit   prev_low  [CH];

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_st[i] = M_OFF; m_left[i] = 0;
      run[i] = 0; mindt[i] = 0; last_side[i] = 0; prev_low[i] = 1'b1;
    end
    m_brk = 1'b0;
  endfunction

  function automatic void m_enter(int i, logic hi, int dt);
    if (dt == 0) m_st[i] = hi ? M_HIGH : M_LOW;
    else begin
      m_st[i]   = hi ? M_DH : M_DL;
      m_left[i] = dt;
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  function automatic void model_edge();
    logic p;
    int   dt;
    dt = int'(bus.dt_i);
    for (int i = 0; i < CH; i++) begin
      p = bus.pwm_i[i];
      if (bus.brk_i || !bus.en_i || m_brk) begin
        m_st[i] = M_OFF; m_left[i] = 0;
      end else begin
        case (m_st[i])
          M_OFF:  m_enter(i, p, dt);
          M_LOW:  if (p)  m_enter(i, 1'b1, dt);
          M_HIGH: if (!p) m_enter(i, 1'b0, dt);
          M_DH: begin
            if (!p)                m_st[i] = M_LOW;
            else if (m_left[i] == 1) m_st[i] = M_HIGH;
            else                   m_left[i]--;
          end
          M_DL: begin
            if (p)                 m_st[i] = M_HIGH;
            else if (m_left[i] == 1) m_st[i] = M_LOW;
            else                   m_left[i]--;
          end
          default: m_st[i] = M_OFF;
        endcase
      end
    end
    m_brk = bus.brk_i || (m_brk && bus.en_i);
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    o[2*CH] = m_brk;
    for (int i = 0; i < CH; i++) begin
      o[CH+i] = (m_st[i] == M_HIGH);
      o[i]    = (m_st[i] == M_LOW);
    end
    return o;
  endfunction

  // One clock: push model expectation, pop and compare after the edge, track dead time
  task automatic step();
    obs_t got, want;
    int   dt_a, side, need, have;
    bit   forced;
    dt_a   = int'(bus.dt_i);
    forced = bus.brk_i || !bus.en_i || bus.brk_o;
    model_edge();
    exp_q.push_back(model_obs());
    @(posedge clk_i);
    #1;
    got  = {bus.brk_o, bus.pwm_h_o, bus.pwm_l_o};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL scoreboard @%0t: got brk/h/l=%b, expected %b", $time, got, want);
    end
    for (int i = 0; i < CH; i++) begin
      if (forced) last_side[i] = 0;
      if (!got[CH+i] && !got[i]) begin
        if (prev_low[i]) begin
          run[i]++;
          if (dt_a < mindt[i]) mindt[i] = dt_a;
        end else begin
          run[i] = 1; mindt[i] = dt_a;
        end
        prev_low[i] = 1'b1;
      end else begin
        side = got[CH+i] ? 1 : 2;
        if (last_side[i] != 0 && side != last_side[i]) begin
          need = prev_low[i] ? mindt[i] : dt_a;
          have = prev_low[i] ? run[i] : 0;
          vectors++;
          if (have < need) begin
            miscompares++;
            $display("FAIL deadtime ch%0d @%0t: %0d low cycles, required %0d", i, $time, have, need);
          end
        end
        last_side[i] = side;
        prev_low[i]  = 1'b0;
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      vectors++;
      if (|(bus.pwm_h_o & bus.pwm_l_o)) begin
        miscompares++;
        $display("FAIL overlap @%0t: h=%b l=%b, required h&l=0", $time, bus.pwm_h_o, bus.pwm_l_o);
      end
    end
  end

  task automatic test_reset();
    obs_t got;
    repeat (2) @(posedge clk_i);
    #1;
    got = {bus.brk_o, bus.pwm_h_o, bus.pwm_l_o};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got brk/h/l=%b, expected all zero", got);
    end
    rst_i = 1'b0;
    model_reset();
    repeat (2) step();
  endtask

  task automatic test_dead_rise();
    bus.en_i = 1'b1; bus.dt_i = DW'(3); bus.pwm_i = '0;
    repeat (5) step();
    vectors++;
    if (bus.pwm_l_o !== 4'b1111 || bus.pwm_h_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL dead_rise_init: h=%b l=%b, expected h=0000 l=1111", bus.pwm_h_o, bus.pwm_l_o);
    end
    bus.pwm_i[0] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      vectors++;
      if (bus.pwm_h_o !== {3'b000, n >= 4} || bus.pwm_l_o !== 4'b1110) begin
        miscompares++;
        $display("FAIL dead_rise step %0d: h=%b l=%b, expected h=%b l=1110",
                 n, bus.pwm_h_o, bus.pwm_l_o, {3'b000, n >= 4});
      end
    end
  endtask

  task automatic test_dt_zero();
    logic [CH-1:0] p;
    p = '0;
    bus.dt_i = '0;
    for (int c = 0; c < 20; c++) begin
      if (c % 5 == 0) p = ~p;
      bus.pwm_i = p;
      step();
      vectors++;
      if (bus.pwm_h_o !== p || bus.pwm_l_o !== ~p) begin
        miscompares++;
        $display("FAIL dt_zero cycle %0d: h=%b l=%b, expected h=%b l=%b", c, bus.pwm_h_o, bus.pwm_l_o, p, ~p);
      end
    end
  endtask

  task automatic test_glitch();
    bus.dt_i = DW'(4); bus.pwm_i = '1;
    repeat (6) step();
    vectors++;
    if (bus.pwm_h_o !== 4'b1111) begin
      miscompares++;
      $display("FAIL glitch_init: h=%b, expected 1111", bus.pwm_h_o);
    end
    for (int n = 1; n <= 5; n++) begin
      bus.pwm_i = (n <= 2) ? 4'b0000 : 4'b1111;
      step();
      vectors++;
      if (bus.pwm_l_o !== 4'b0000 || bus.pwm_h_o !== ((n >= 3) ? 4'b1111 : 4'b0000)) begin
        miscompares++;
        $display("FAIL glitch step %0d: h=%b l=%b, expected l=0000", n, bus.pwm_h_o, bus.pwm_l_o);
      end
    end
  endtask

  task automatic test_break();
    bus.pwm_i = '0; bus.dt_i = '0;
    step();
    bus.pwm_i = '1; bus.dt_i = DW'(10);
    repeat (4) step();
    bus.brk_i = 1'b1;
    step();
    bus.brk_i = 1'b0;
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (bus.brk_o !== 1'b1 || bus.pwm_h_o !== '0 || bus.pwm_l_o !== '0) begin
        miscompares++;
        $display("FAIL break_hold %0d: brk=%b h=%b l=%b, expected brk=1 h=0 l=0",
                 n, bus.brk_o, bus.pwm_h_o, bus.pwm_l_o);
      end
      if (n < 3) step();
    end
    bus.en_i = 1'b0;
    step();
    vectors++;
    if (bus.brk_o !== 1'b0) begin
      miscompares++;
      $display("FAIL break_clear: brk=%b, expected 0", bus.brk_o);
    end
    bus.en_i = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      if (n == 3) bus.dt_i = DW'(1);
      step();
      vectors++;
      if (bus.pwm_l_o !== '0 || bus.pwm_h_o !== ((n >= 11) ? 4'b1111 : 4'b0000)) begin
        miscompares++;
        $display("FAIL break_resume step %0d: h=%b l=%b", n, bus.pwm_h_o, bus.pwm_l_o);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst_i = 1'b1;
    #1;
    vectors++;
    if (bus.pwm_h_o !== '0 || bus.pwm_l_o !== '0 || bus.brk_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: h=%b l=%b brk=%b, expected all zero", bus.pwm_h_o, bus.pwm_l_o, bus.brk_o);
    end
    model_reset();
    bus.en_i = 1'b1; bus.dt_i = DW'(2); bus.pwm_i = '1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      step();
      vectors++;
      if (bus.pwm_l_o !== '0 || bus.pwm_h_o !== ((n >= 3) ? 4'b1111 : 4'b0000)) begin
        miscompares++;
        $display("FAIL reset_release step %0d: h=%b l=%b", n, bus.pwm_h_o, bus.pwm_l_o);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      bus.brk_i = ($urandom_range(0, 63) == 0);
      bus.en_i  = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 49) == 0) bus.dt_i = DW'($urandom_range(0, 6));
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 5) == 0) bus.pwm_i[i] = ~bus.pwm_i[i];
      step();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.en_i = 1'b0; bus.brk_i = 1'b0; bus.dt_i = '0; bus.pwm_i = '0;
    model_reset();
    test_reset();
    test_dead_rise();
    test_dt_zero();
    test_glitch();
    test_break();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
